// File: rtl/cpu7_csr_byp_stage.sv
// One tracked pipeline stage of the CSR bypass: valid, address and (optionally) write data.
// Stages at or before the data-producing stage carry no data register.
module cpu7_csr_byp_stage #(
   parameter int AW       = 12,
   parameter int DW       = 32,
   parameter bit HAS_DATA = 1'b1
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          adv_i,
   input  logic          kill_i,
   input  logic          vld_i,
   input  logic [AW-1:0] addr_i,
   input  logic [DW-1:0] data_i,
   output logic          vld_o,
   output logic [AW-1:0] addr_o,
   output logic [DW-1:0] data_o
);
   logic          vld_q;
   logic [AW-1:0] addr_q;

   // kill wins over advance so a flushed entry never survives the edge
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         vld_q  <= 1'b0;
         addr_q <= '0;
      end else begin
         if (kill_i)     vld_q <= 1'b0;
         else if (adv_i) vld_q <= vld_i;
         if (adv_i)      addr_q <= addr_i;
      end
   end

   generate
      if (HAS_DATA) begin : g_data
         logic [DW-1:0] data_q;
         always_ff @(posedge clk or negedge resetn) begin
            if (!resetn)    data_q <= '0;
            else if (adv_i) data_q <= data_i;
         end
         assign data_o = data_q;
      end else begin : g_nodata
         logic unused_data;
         assign unused_data = ^data_i;
         assign data_o      = '0;
      end
   endgenerate

   assign vld_o  = vld_q;
   assign addr_o = addr_q;
endmodule

// File: rtl/cpu7_csr_byp_pipe.sv
// CSR read-after-write bypass: tracks in-flight CSR writes from issue to commit, forwards the
// youngest matching value to a decode-stage read, stalls when that data is not produced yet.
`ifndef LCSR_BIT
`define LCSR_BIT 12
`endif

module cpu7_csr_byp_pipe #(
   parameter int CSR_AW   = `LCSR_BIT,
   parameter int DW       = 32,
   parameter int NSTAGE   = 3,
   parameter int DATA_STG = 1,
   parameter int CNT_W    = 16
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              pipe_adv,
   input  logic              flush,
   input  logic              issue_d,
   input  logic              csr_ren_d,
   input  logic [CSR_AW-1:0] csr_raddr_d,
   input  logic              csr_wen_d,
   input  logic [CSR_AW-1:0] csr_waddr_d,
   input  logic [DW-1:0]     csr_wdata_in,
   input  logic              csr_wdata_vld,
   input  logic [DW-1:0]     csr_rdata_rf,
   output logic [DW-1:0]     csr_rdata_d,
   output logic              csr_byp_hit,
   output logic              csr_byp_stall,
   output logic              csr_rf_we,
   output logic [CSR_AW-1:0] csr_rf_waddr,
   output logic [DW-1:0]     csr_rf_wdata,
   output logic [CNT_W-1:0]  csr_stall_cnt
);
   logic [NSTAGE-1:0]             vld_q, vld_in, m, sel;
   logic [NSTAGE-1:0][CSR_AW-1:0] addr_q, addr_in;
   logic [NSTAGE-1:0][DW-1:0]     data_q, data_in;
   logic [CNT_W-1:0]              stall_cnt_q, stall_cnt_d;

   genvar g;
   generate
      for (g = 0; g < NSTAGE; g++) begin : g_stg
         localparam bit KILLABLE = (g < NSTAGE - 1);
         // a stalled decode enters stage 0 as a bubble
         if (g == 0) begin : g_head
            assign vld_in[g]  = issue_d & csr_wen_d & ~csr_byp_stall;
            assign addr_in[g] = csr_waddr_d;
         end else begin : g_body
            assign vld_in[g]  = vld_q[g-1] & ~flush;
            assign addr_in[g] = addr_q[g-1];
         end
         if (g == DATA_STG + 1) begin : g_dcap
            assign data_in[g] = csr_wdata_in;
         end else if (g > DATA_STG + 1) begin : g_dmov
            assign data_in[g] = data_q[g-1];
         end else begin : g_dnone
            assign data_in[g] = '0;
         end

         cpu7_csr_byp_stage #(
            .AW      (CSR_AW),
            .DW      (DW),
            .HAS_DATA(g > DATA_STG)
         ) u_stg (
            .clk   (clk),
            .resetn(resetn),
            .adv_i (pipe_adv),
            .kill_i(flush & KILLABLE),
            .vld_i (vld_in[g]),
            .addr_i(addr_in[g]),
            .data_i(data_in[g]),
            .vld_o (vld_q[g]),
            .addr_o(addr_q[g]),
            .data_o(data_q[g])
         );

         assign m[g] = vld_q[g] & (addr_q[g] == csr_raddr_d) & csr_ren_d;
         // lowest index is the youngest write
         if (g == 0) begin : g_pe0
            assign sel[g] = m[g];
         end else begin : g_pen
            assign sel[g] = m[g] & ~(|m[g-1:0]);
         end
      end
   endgenerate

   always_comb begin
      csr_rdata_d   = csr_rdata_rf;
      csr_byp_hit   = 1'b0;
      csr_byp_stall = 1'b0;
      for (int i = 0; i < NSTAGE; i++) begin
         if (sel[i]) begin
            if (i < DATA_STG) begin
               csr_byp_stall = 1'b1;
            end else if (i == DATA_STG) begin
               csr_byp_hit   = csr_wdata_vld;
               csr_byp_stall = ~csr_wdata_vld;
               if (csr_wdata_vld) csr_rdata_d = csr_wdata_in;
            end else begin
               csr_byp_hit = 1'b1;
               csr_rdata_d = data_q[i];
            end
         end
      end
   end

   // the file is written only at the edge, so a commit-stage match still forwards above
   assign csr_rf_we    = vld_q[NSTAGE-1] & pipe_adv;
   assign csr_rf_waddr = addr_q[NSTAGE-1];
   assign csr_rf_wdata = data_q[NSTAGE-1];

   assign stall_cnt_d = (csr_byp_stall && (stall_cnt_q != {CNT_W{1'b1}})) ?
                        stall_cnt_q + CNT_W'(1) : stall_cnt_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) stall_cnt_q <= '0;
      else         stall_cnt_q <= stall_cnt_d;
   end

   assign csr_stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_cpu7_csr_byp_pipe.sv
// Directed bench for cpu7_csr_byp_pipe with NSTAGE=3 (E,M,W) and DATA_STG=1.
module tb_cpu7_csr_byp_pipe;
   localparam int AW = 12;
   localparam int DW = 32;
   localparam int CW = 16;
   localparam logic [DW-1:0] RF = 32'h0BAD_F11E;

   logic          clk = 1'b0;
   logic          resetn;
   logic          pipe_adv, flush, issue_d, csr_ren_d, csr_wen_d, csr_wdata_vld;
   logic [AW-1:0] csr_raddr_d, csr_waddr_d;
   logic [DW-1:0] csr_wdata_in, csr_rdata_rf;
   logic [DW-1:0] csr_rdata_d, csr_rf_wdata;
   logic          csr_byp_hit, csr_byp_stall, csr_rf_we;
   logic [AW-1:0] csr_rf_waddr;
   logic [CW-1:0] csr_stall_cnt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   cpu7_csr_byp_pipe #(.CSR_AW(AW), .DW(DW), .NSTAGE(3), .DATA_STG(1), .CNT_W(CW)) dut (
      .clk(clk), .resetn(resetn), .pipe_adv(pipe_adv), .flush(flush), .issue_d(issue_d),
      .csr_ren_d(csr_ren_d), .csr_raddr_d(csr_raddr_d), .csr_wen_d(csr_wen_d),
      .csr_waddr_d(csr_waddr_d), .csr_wdata_in(csr_wdata_in), .csr_wdata_vld(csr_wdata_vld),
      .csr_rdata_rf(csr_rdata_rf), .csr_rdata_d(csr_rdata_d), .csr_byp_hit(csr_byp_hit),
      .csr_byp_stall(csr_byp_stall), .csr_rf_we(csr_rf_we), .csr_rf_waddr(csr_rf_waddr),
      .csr_rf_wdata(csr_rf_wdata), .csr_stall_cnt(csr_stall_cnt)
   );

   // start of a cycle: inputs change at the falling edge, default to idle with the pipe advancing
   task automatic cyc();
      @(negedge clk);
      pipe_adv = 1'b1; flush = 1'b0; issue_d = 1'b0; csr_ren_d = 1'b0; csr_wen_d = 1'b0;
      csr_raddr_d = '0; csr_waddr_d = '0; csr_wdata_in = '0; csr_wdata_vld = 1'b0;
      csr_rdata_rf = RF;
   endtask

   task automatic wr(input logic [AW-1:0] a);
      issue_d = 1'b1; csr_wen_d = 1'b1; csr_waddr_d = a;
   endtask

   task automatic rd(input logic [AW-1:0] a);
      csr_ren_d = 1'b1; csr_raddr_d = a;
   endtask

   task automatic test_reset();
      cyc(); rd(12'h010); #1;
      checks++; if (csr_rf_we !== 1'b0) begin errors++; $display("FAIL rst_we got %0b exp 0", csr_rf_we); end
      checks++; if (csr_byp_stall !== 1'b0 || csr_byp_hit !== 1'b0) begin errors++; $display("FAIL rst_stall_hit got %0b%0b exp 00", csr_byp_stall, csr_byp_hit); end
      checks++; if (csr_rdata_d !== RF) begin errors++; $display("FAIL rst_rdata got %h exp %h", csr_rdata_d, RF); end
      checks++; if (csr_stall_cnt !== 16'h0) begin errors++; $display("FAIL rst_cnt got %h exp 0", csr_stall_cnt); end
      resetn = 1'b1;
      cyc(); wr(12'h010);
      cyc(); wr(12'h011);
      cyc(); wr(12'h012); csr_wdata_vld = 1'b1; csr_wdata_in = 32'h1010;
      cyc(); pipe_adv = 1'b0; rd(12'h012); #1;
      checks++; if (csr_byp_stall !== 1'b1) begin errors++; $display("FAIL rst_pre_stall got %0b exp 1", csr_byp_stall); end
      cyc(); rd(12'h010); #1;
      checks++; if (csr_rf_we !== 1'b1 || csr_rf_waddr !== 12'h010 || csr_rf_wdata !== 32'h1010) begin errors++; $display("FAIL rst_pre_commit got %0b %h %h exp 1 010 00001010", csr_rf_we, csr_rf_waddr, csr_rf_wdata); end
      checks++; if (csr_byp_hit !== 1'b1 || csr_rdata_d !== 32'h1010) begin errors++; $display("FAIL rst_pre_whit got %0b %h exp 1 00001010", csr_byp_hit, csr_rdata_d); end
      checks++; if (csr_stall_cnt !== 16'd1) begin errors++; $display("FAIL rst_pre_cnt got %0d exp 1", csr_stall_cnt); end
      resetn = 1'b0;
      cyc(); rd(12'h012); #1;
      checks++; if (csr_byp_stall !== 1'b0 || csr_byp_hit !== 1'b0 || csr_rdata_d !== RF) begin errors++; $display("FAIL rst_mid_read got %0b%0b %h exp 00 %h", csr_byp_stall, csr_byp_hit, csr_rdata_d, RF); end
      checks++; if (csr_rf_we !== 1'b0 || csr_stall_cnt !== 16'h0) begin errors++; $display("FAIL rst_mid_state got %0b %h exp 0 0", csr_rf_we, csr_stall_cnt); end
      resetn = 1'b1;
   endtask

   task automatic test_stall_hit();
      cyc(); wr(12'h005);
      cyc(); rd(12'h005); #1;
      checks++; if (csr_byp_stall !== 1'b1 || csr_byp_hit !== 1'b0) begin errors++; $display("FAIL e_stall got %0b%0b exp 10", csr_byp_stall, csr_byp_hit); end
      cyc(); rd(12'h005); csr_wdata_vld = 1'b1; csr_wdata_in = 32'hA5A5; #1;
      checks++; if (csr_byp_stall !== 1'b0 || csr_byp_hit !== 1'b1 || csr_rdata_d !== 32'hA5A5) begin errors++; $display("FAIL m_hit got %0b%0b %h exp 01 0000a5a5", csr_byp_stall, csr_byp_hit, csr_rdata_d); end
      cyc(); rd(12'h005); #1;
      checks++; if (csr_byp_hit !== 1'b1 || csr_rdata_d !== 32'hA5A5) begin errors++; $display("FAIL w_hit got %0b %h exp 1 0000a5a5", csr_byp_hit, csr_rdata_d); end
      checks++; if (csr_rf_we !== 1'b1 || csr_rf_waddr !== 12'h005 || csr_rf_wdata !== 32'hA5A5) begin errors++; $display("FAIL w_commit got %0b %h %h exp 1 005 0000a5a5", csr_rf_we, csr_rf_waddr, csr_rf_wdata); end
      cyc(); rd(12'h005); #1;
      checks++; if (csr_byp_hit !== 1'b0 || csr_byp_stall !== 1'b0 || csr_rdata_d !== RF || csr_rf_we !== 1'b0) begin errors++; $display("FAIL post_commit got %0b%0b %h %0b exp 00 %h 0", csr_byp_hit, csr_byp_stall, csr_rdata_d, csr_rf_we, RF); end
      checks++; if (csr_stall_cnt !== 16'd1) begin errors++; $display("FAIL sh_cnt got %0d exp 1", csr_stall_cnt); end
   endtask

   task automatic test_youngest();
      cyc(); wr(12'h005);
      cyc(); wr(12'h005);
      cyc(); csr_wdata_vld = 1'b1; csr_wdata_in = 32'h11;
      cyc(); rd(12'h005); csr_wdata_vld = 1'b1; csr_wdata_in = 32'h22; #1;
      checks++; if (csr_byp_hit !== 1'b1 || csr_byp_stall !== 1'b0 || csr_rdata_d !== 32'h22) begin errors++; $display("FAIL young_mw got %0b%0b %h exp 10 00000022", csr_byp_hit, csr_byp_stall, csr_rdata_d); end
      checks++; if (csr_rf_we !== 1'b1 || csr_rf_wdata !== 32'h11) begin errors++; $display("FAIL young_commit1 got %0b %h exp 1 00000011", csr_rf_we, csr_rf_wdata); end
      cyc(); rd(12'h005); #1;
      checks++; if (csr_byp_hit !== 1'b1 || csr_rdata_d !== 32'h22 || csr_rf_wdata !== 32'h22) begin errors++; $display("FAIL young_w got %0b %h %h exp 1 00000022 00000022", csr_byp_hit, csr_rdata_d, csr_rf_wdata); end
   endtask

   task automatic test_flush();
      cyc(); wr(12'h020);
      cyc(); wr(12'h021);
      cyc(); wr(12'h022); csr_wdata_vld = 1'b1; csr_wdata_in = 32'h20;
      cyc(); flush = 1'b1; csr_wdata_vld = 1'b1; csr_wdata_in = 32'h21; rd(12'h021); #1;
      checks++; if (csr_byp_hit !== 1'b1 || csr_rdata_d !== 32'h21) begin errors++; $display("FAIL fl_mhit got %0b %h exp 1 00000021", csr_byp_hit, csr_rdata_d); end
      checks++; if (csr_rf_we !== 1'b1 || csr_rf_waddr !== 12'h020 || csr_rf_wdata !== 32'h20) begin errors++; $display("FAIL fl_commit got %0b %h %h exp 1 020 00000020", csr_rf_we, csr_rf_waddr, csr_rf_wdata); end
      cyc(); rd(12'h021); #1;
      checks++; if (csr_byp_hit !== 1'b0 || csr_byp_stall !== 1'b0 || csr_rdata_d !== RF || csr_rf_we !== 1'b0) begin errors++; $display("FAIL fl_after_m got %0b%0b %h %0b exp 00 %h 0", csr_byp_hit, csr_byp_stall, csr_rdata_d, csr_rf_we, RF); end
      cyc(); rd(12'h022); #1;
      checks++; if (csr_byp_hit !== 1'b0 || csr_byp_stall !== 1'b0) begin errors++; $display("FAIL fl_after_e got %0b%0b exp 00", csr_byp_hit, csr_byp_stall); end
   endtask

   task automatic test_self_read();
      cyc(); wr(12'h030); rd(12'h030); #1;
      checks++; if (csr_byp_stall !== 1'b0 || csr_byp_hit !== 1'b0 || csr_rdata_d !== RF) begin errors++; $display("FAIL self_read got %0b%0b %h exp 00 %h", csr_byp_stall, csr_byp_hit, csr_rdata_d, RF); end
      cyc(); rd(12'h030); wr(12'h031); #1;
      checks++; if (csr_byp_stall !== 1'b1) begin errors++; $display("FAIL self_next_stall got %0b exp 1", csr_byp_stall); end
      cyc(); rd(12'h031); csr_wdata_vld = 1'b1; csr_wdata_in = 32'h30; #1;
      checks++; if (csr_byp_stall !== 1'b0 || csr_byp_hit !== 1'b0) begin errors++; $display("FAIL bubble got %0b%0b exp 00", csr_byp_stall, csr_byp_hit); end
      cyc(); rd(12'h030); #1;
      checks++; if (csr_byp_hit !== 1'b1 || csr_rdata_d !== 32'h30 || csr_rf_waddr !== 12'h030) begin errors++; $display("FAIL self_w got %0b %h %h exp 1 00000030 030", csr_byp_hit, csr_rdata_d, csr_rf_waddr); end
   endtask

   task automatic test_hold();
      cyc(); wr(12'h040);
      cyc();
      for (int k = 0; k < 5; k++) begin
         cyc(); pipe_adv = 1'b0; rd(12'h040); #1;
         checks++; if (csr_byp_stall !== 1'b1 || csr_rf_we !== 1'b0) begin errors++; $display("FAIL hold_%0d got %0b %0b exp 1 0", k, csr_byp_stall, csr_rf_we); end
      end
      cyc(); rd(12'h040); csr_wdata_vld = 1'b1; csr_wdata_in = 32'h4040; #1;
      checks++; if (csr_byp_hit !== 1'b1 || csr_byp_stall !== 1'b0 || csr_rdata_d !== 32'h4040) begin errors++; $display("FAIL hold_release got %0b%0b %h exp 10 00004040", csr_byp_hit, csr_byp_stall, csr_rdata_d); end
      cyc(); #1;
      checks++; if (csr_rf_we !== 1'b1 || csr_rf_waddr !== 12'h040 || csr_rf_wdata !== 32'h4040) begin errors++; $display("FAIL hold_commit got %0b %h %h exp 1 040 00004040", csr_rf_we, csr_rf_waddr, csr_rf_wdata); end
      checks++; if (csr_stall_cnt !== 16'd7) begin errors++; $display("FAIL hold_cnt got %0d exp 7", csr_stall_cnt); end
   endtask

   task automatic test_saturate();
      cyc(); wr(12'h050);
      for (int k = 0; k < 70000; k++) begin
         cyc(); pipe_adv = 1'b0; rd(12'h050);
      end
      #1;
      checks++; if (csr_stall_cnt !== 16'hFFFF || csr_byp_stall !== 1'b1) begin errors++; $display("FAIL sat_cnt got %h %0b exp ffff 1", csr_stall_cnt, csr_byp_stall); end
      for (int k = 0; k < 3; k++) begin
         cyc(); pipe_adv = 1'b0; rd(12'h050);
      end
      #1;
      checks++; if (csr_stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_hold got %h exp ffff", csr_stall_cnt); end
      resetn = 1'b0; #1;
      checks++; if (csr_stall_cnt !== 16'h0 || csr_byp_stall !== 1'b0) begin errors++; $display("FAIL sat_reset got %h %0b exp 0 0", csr_stall_cnt, csr_byp_stall); end
      resetn = 1'b1;
   endtask

   initial begin
      resetn = 1'b0;
      pipe_adv = 1'b1; flush = 1'b0; issue_d = 1'b0; csr_ren_d = 1'b0; csr_wen_d = 1'b0;
      csr_raddr_d = '0; csr_waddr_d = '0; csr_wdata_in = '0; csr_wdata_vld = 1'b0;
      csr_rdata_rf = RF;
      test_reset();
      test_stall_hit();
      test_youngest();
      test_flush();
      test_self_read();
      test_hold();
      test_saturate();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
